sim_traffic_sched: RTL

//  Sequencer for the simulated-traffic source feeding the DDR FIFO write side. On a start edge it

---
 rtl/sim_traffic_pkg.sv | 29 ++
 rtl/sim_pattern_gen.sv | 45 ++++
 rtl/sim_traffic_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sim_traffic_pkg.sv
// Shared definitions for the simulated-traffic sequencer: default widths,
// FSM state encoding and a saturating counter helper.
package sim_traffic_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_NB_W   = 16;
  localparam int DEF_GAP_W  = 8;

  // Pattern counter width; one pattern byte is replicated across the data word.
  localparam int PAT_W = 8;

  // Width of the progress counter reported to the config logic.
  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_BURST,
    ST_GAP,
    ST_DONE
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sim_pattern_gen.sv
// 8-bit pattern counter plus the registered output stage. The counter is
// cleared at the start of a run and advances once per issued word; the
// issued word is the pre-increment pattern replicated across DATA_W.
module sim_pattern_gen
  import sim_traffic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W  // must be a multiple of PAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  localparam int REP = DATA_W / PAT_W;

  logic [PAT_W-1:0] pat;

  // Pattern counter: clear on run start, step on every issued word (wraps 255->0).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat <= '0;
    end else if (clear) begin
      pat <= '0;
    end else if (advance) begin
      pat <= pat + 1'b1;
    end
  end

  // Output register: the word issued this cycle is presented on the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= advance;
      data_out   <= advance ? {REP{pat}} : '0;
    end
  end

endmodule

// File: rtl/sim_traffic_sched.sv
// Sequencer for the simulated-traffic source on the DDR FIFO write side.
// A start rising edge launches a run of cfg_nburst bursts of cfg_len words,
// separated by cfg_gap idle cycles; issue stalls while fifo_afull is high and
// stop aborts the run. Configuration is captured once per run in ARM.
module sim_traffic_sched
  import sim_traffic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int NB_W   = DEF_NB_W,
  parameter int GAP_W  = DEF_GAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [NB_W-1:0]   cfg_nburst,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              fifo_afull,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_sent
);

  state_e state, state_nxt;

  logic start_q;
  logic start_rise;

  // Run configuration, frozen for the duration of a run.
  logic [LEN_W-1:0] len_q;
  logic [NB_W-1:0]  nb_q;
  logic [GAP_W-1:0] gap_q;

  logic [LEN_W-1:0] word_cnt;
  logic [NB_W-1:0]  burst_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic arm;
  logic issue;
  logic burst_end;
  logic last_word;
  logic last_burst;

  assign start_rise = start & ~start_q;
  assign last_word  = (word_cnt == len_q - 1'b1);
  assign last_burst = (nb_q != '0) && (burst_cnt == nb_q - 1'b1);

  // Start-edge detector; sampled every cycle so an edge seen while busy is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and issue decision.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    issue     = 1'b0;
    burst_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_rise && !stop) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        arm       = 1'b1;
        state_nxt = stop ? ST_DONE : ST_BURST;
      end
      ST_BURST: begin
        if (stop) begin
          state_nxt = ST_DONE;
        end else if (!fifo_afull) begin
          issue = 1'b1;
          if (last_word) begin
            burst_end = 1'b1;
            if (last_burst)         state_nxt = ST_DONE;
            else if (gap_q == '0)   state_nxt = ST_BURST;
            else                    state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        // gap_q is nonzero whenever GAP is entered, so the subtraction cannot wrap.
        if (stop)                             state_nxt = ST_DONE;
        else if (gap_cnt == gap_q - 1'b1)     state_nxt = ST_BURST;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Config capture in ARM, plus word/burst/gap counters and progress count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      nb_q       <= '0;
      gap_q      <= '0;
      word_cnt   <= '0;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
      words_sent <= '0;
    end else if (arm) begin
      // A zero burst length behaves as a single-word burst.
      len_q      <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
      nb_q       <= cfg_nburst;
      gap_q      <= cfg_gap;
      word_cnt   <= '0;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
      words_sent <= '0;
    end else begin
      if (issue) begin
        words_sent <= sat_inc(words_sent);
        word_cnt   <= burst_end ? '0 : word_cnt + 1'b1;
        if (burst_end) burst_cnt <= burst_cnt + 1'b1;
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  sim_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (arm),
    .advance    (issue),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

endmodule
